// File: rtl/vdp_vram_slot_scheduler.sv
// VRAM slot scheduler for the VDP.
//
// Splits each raster line's VRAM bandwidth between the line renderer, the CPU port and the
// DMA port. On every line that needs a prefetch the renderer owns VRAM exclusively for a
// sprite-scan phase followed by a tile-fetch phase; the rest of the line, and every line that
// does not prefetch, is shared round-robin between CPU and DMA.
//
// Ports:
//   clk_i, reset_ni        pixel clock, asynchronous active-low reset
//   line_ended_i           one-cycle pulse, raster_y_i already holds the new line
//   frame_ended_i          one-cycle pulse alongside line_ended_i when the raster wraps to 0
//   raster_y_i             current line from the timing generator
//   render_line_start_o    one-cycle pulse in the first sprite-phase cycle
//   render_sprite_en_o     high throughout the sprite phase
//   render_tile_en_o       high throughout the tile phase
//   fetch_line_o           line being prefetched (raster_y_i + 1, wrapping to 0)
//   cpu_req_i / cpu_ack_o  CPU level request / one-cycle grant
//   dma_req_i / dma_ack_o  DMA level request / one-cycle grant
//   vram_owner_o           0 none, 1 render, 2 cpu, 3 dma
//   overrun_o              sticky flag: a line ended while the renderer still owned VRAM
//   overrun_clear_i        synchronous clear for overrun_o (a simultaneous set wins)
module vdp_vram_slot_scheduler #(
  parameter int unsigned SpriteSlots   = 256,
  parameter int unsigned TileSlots     = 512,
  parameter int unsigned VActiveHeight = 480,
  parameter int unsigned VSize         = 517
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       line_ended_i,
  input  logic       frame_ended_i,
  input  logic [9:0] raster_y_i,
  output logic       render_line_start_o,
  output logic       render_sprite_en_o,
  output logic       render_tile_en_o,
  output logic [9:0] fetch_line_o,
  input  logic       cpu_req_i,
  output logic       cpu_ack_o,
  input  logic       dma_req_i,
  output logic       dma_ack_o,
  output logic [1:0] vram_owner_o,
  output logic       overrun_o,
  input  logic       overrun_clear_i
);

  typedef enum logic [1:0] {
    StIdle,
    StSprite,
    StTile,
    StFree
  } phase_e;

  localparam logic [9:0] SpriteLast   = 10'(SpriteSlots - 1);
  localparam logic [9:0] TileLast     = 10'(TileSlots - 1);
  localparam logic [9:0] LastLine     = 10'(VSize - 1);
  localparam logic [9:0] LastActive   = 10'(VActiveHeight - 1);

  localparam logic [1:0] OwnerNone   = 2'd0;
  localparam logic [1:0] OwnerRender = 2'd1;
  localparam logic [1:0] OwnerCpu    = 2'd2;
  localparam logic [1:0] OwnerDma    = 2'd3;

  // Round-robin pointer encoding: which requester wins a tie.
  localparam logic RrCpu = 1'b0;
  localparam logic RrDma = 1'b1;

  phase_e     phase_q, phase_d;
  logic [9:0] cnt_q, cnt_d;
  logic [9:0] fetch_line_q, fetch_line_d;
  logic       start_q, start_d;
  logic       rr_q, rr_d;
  logic       cpu_ack_q, cpu_ack_d;
  logic       dma_ack_q, dma_ack_d;
  logic       overrun_q, overrun_d;

  logic       last_line;
  logic       prefetch;
  logic       overrun_set;
  logic       grant_allowed;
  logic       cpu_cand;
  logic       dma_cand;

  // The last blank line prefetches line 0; the last active line has nothing to prefetch.
  assign last_line = (raster_y_i == LastLine);
  assign prefetch  = last_line || (raster_y_i < LastActive);

  // ---------------------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      phase_q      <= StIdle;
      cnt_q        <= '0;
      fetch_line_q <= '0;
      start_q      <= 1'b0;
      rr_q         <= RrCpu;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      fetch_line_q <= fetch_line_d;
      start_q      <= start_d;
      rr_q         <= rr_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
      overrun_q    <= overrun_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Next-state logic: phase sequencing and slot counter
  // ---------------------------------------------------------------------------------------
  always_comb begin
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    fetch_line_d = fetch_line_q;
    start_d      = 1'b0;
    overrun_set  = 1'b0;

    if (line_ended_i) begin
      // A new line always restarts the schedule, even if the renderer had not finished.
      overrun_set = (phase_q == StSprite) || (phase_q == StTile);
      cnt_d       = '0;
      if (prefetch) begin
        phase_d      = StSprite;
        start_d      = 1'b1;
        fetch_line_d = last_line ? 10'd0 : raster_y_i + 10'd1;
      end else begin
        phase_d = StIdle;
      end
    end else begin
      unique case (phase_q)
        StSprite: begin
          if (cnt_q == SpriteLast) begin
            phase_d = StTile;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        StTile: begin
          if (cnt_q == TileLast) begin
            phase_d = StFree;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        StIdle, StFree: begin
          // Free arbitration; counter holds until the next line.
        end
      endcase
    end
  end

  // Set takes priority over clear so a fresh overrun is never lost.
  always_comb begin
    overrun_d = overrun_q;
    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (overrun_clear_i) begin
      overrun_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------------------
  // CPU / DMA arbitration
  // ---------------------------------------------------------------------------------------
  // Grants are judged against the phase of the next cycle, so the ack never lands inside a
  // render phase and no grant is issued on the edge entering the sprite phase.
  assign grant_allowed = (phase_d == StFree) || (phase_d == StIdle);

  // A requester acked this cycle sits out one decision, so acks are never back to back.
  assign cpu_cand = cpu_req_i && !cpu_ack_q;
  assign dma_cand = dma_req_i && !dma_ack_q;

  always_comb begin
    cpu_ack_d = 1'b0;
    dma_ack_d = 1'b0;
    rr_d      = rr_q;
    if (grant_allowed) begin
      if (cpu_cand && dma_cand) begin
        if (rr_q == RrCpu) begin
          cpu_ack_d = 1'b1;
          rr_d      = RrDma;
        end else begin
          dma_ack_d = 1'b1;
          rr_d      = RrCpu;
        end
      end else if (cpu_cand) begin
        cpu_ack_d = 1'b1;
      end else if (dma_cand) begin
        dma_ack_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Outputs: decoded purely from registered state
  // ---------------------------------------------------------------------------------------
  always_comb begin
    render_line_start_o = start_q;
    render_sprite_en_o  = (phase_q == StSprite);
    render_tile_en_o    = (phase_q == StTile);
    fetch_line_o        = fetch_line_q;
    cpu_ack_o           = cpu_ack_q;
    dma_ack_o           = dma_ack_q;
    overrun_o           = overrun_q;
    vram_owner_o        = OwnerNone;
    if ((phase_q == StSprite) || (phase_q == StTile)) begin
      vram_owner_o = OwnerRender;
    end else if (cpu_ack_q) begin
      vram_owner_o = OwnerCpu;
    end else if (dma_ack_q) begin
      vram_owner_o = OwnerDma;
    end
  end

  // frame_ended_i carries no scheduling meaning; it must only ever accompany a wrap to line 0.
  frame_wrap_a : assert property (@(posedge clk_i) disable iff (!reset_ni)
      frame_ended_i |-> (line_ended_i && (raster_y_i == 10'd0)));

endmodule
